// File: rtl/switch_debouncer.sv
// Per-channel switch debouncer: two-flop synchronizer, then a stability counter
// that accepts a new level only after DEBOUNCE_CYCLES consecutive mismatch cycles.
module switch_debouncer #(
  parameter int WIDTH           = 6,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] SW_RAW,
  output logic [WIDTH-1:0] SW_CLEAN,
  output logic [WIDTH-1:0] SW_EDGE
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] sw_clean_q, sw_clean_d;
  logic [WIDTH-1:0] sw_edge_q, sw_edge_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Counter only runs while the synchronized level disagrees with the accepted one.
  always_comb begin
    sw_clean_d = sw_clean_q;
    sw_edge_d  = '0;
    cnt_d      = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_q[i] == sw_clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        sw_clean_d[i] = s2_q[i];
        sw_edge_d[i]  = 1'b1;
        cnt_d[i]      = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_q       <= '0;
      s2_q       <= '0;
      sw_clean_q <= '0;
      sw_edge_q  <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q       <= SW_RAW;
      s2_q       <= s1_q;
      sw_clean_q <= sw_clean_d;
      sw_edge_q  <= sw_edge_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign SW_CLEAN = sw_clean_q;
  assign SW_EDGE  = sw_edge_q;

endmodule
